maxnet_host: RTL and testbench

- Initiator and sequencer for the Maxnet engine.
- Accepts a serial word stream over a valid/ready handshake, in the order epsilon, a1, a2, a3, a4, and registers the five operands.
- Issues the start pulse, waits for finish with a guard window and a timeout, captures out/overflow, and returns one result record over a valid/ready handshake.
- Sits between the system bus/FIFO side and the Maxnet engine ports.

---
 rtl/maxnet_pkg.sv | 20 ++
 rtl/maxnet_host_if.sv | 44 ++++
 rtl/maxnet_host_timer.sv | 44 ++++
 rtl/maxnet_host.sv | 141 ++++++++++++++
 tb/tb_maxnet_host.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet host sequencer.
package maxnet_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_e;

  // Operand slot order matches the order words arrive on the input stream.
  localparam logic [2:0] IDX_EPS = 3'd0;
  localparam logic [2:0] IDX_A1  = 3'd1;
  localparam logic [2:0] IDX_A2  = 3'd2;
  localparam logic [2:0] IDX_A3  = 3'd3;
  localparam logic [2:0] IDX_A4  = 3'd4;

endpackage

// File: rtl/maxnet_host_if.sv
// Bus bundle between the Maxnet host, its word source / result sink and the engine.
// The master side is the host; the slave side is everything around it.
interface maxnet_host_if #(
  parameter int WORD_W = 32
);

  // Input word stream
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  // Engine side
  logic              mx_start;
  logic [WORD_W-1:0] mx_epsilon;
  logic [WORD_W-1:0] mx_a1;
  logic [WORD_W-1:0] mx_a2;
  logic [WORD_W-1:0] mx_a3;
  logic [WORD_W-1:0] mx_a4;
  logic              mx_finish;
  logic              mx_overflow;
  logic [WORD_W-1:0] mx_out;

  // Result record
  logic              res_valid;
  logic              res_ready;
  logic [WORD_W-1:0] res_data;
  logic              res_overflow;
  logic              res_timeout;

  logic              busy;

  modport master (
    input  in_valid, in_data, mx_finish, mx_overflow, mx_out, res_ready,
    output in_ready, mx_start, mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4,
           res_valid, res_data, res_overflow, res_timeout, busy
  );

  modport slave (
    output in_valid, in_data, mx_finish, mx_overflow, mx_out, res_ready,
    input  in_ready, mx_start, mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4,
           res_valid, res_data, res_overflow, res_timeout, busy
  );

endinterface

// File: rtl/maxnet_host_timer.sv
// Guard / timeout counter for the WAIT phase of the Maxnet host.
// guard_done flags that engine finish may be trusted; timeout flags the last
// allowed WAIT cycle. The counter is one bit wider than needed so it never
// wraps before the timeout point.
module maxnet_host_timer #(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic guard_done,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign guard_done = (cnt_q >= CNT_W'(GUARD_CYCLES));
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/maxnet_host.sv
// Maxnet host: collects five operands from a word stream, starts the engine,
// waits for finish behind a guard window with a timeout, and hands back one
// result record.
module maxnet_host
  import maxnet_pkg::*;
#(
  parameter int WORD_W         = maxnet_pkg::WORD_W,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  maxnet_host_if.master bus
);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [WORD_W-1:0] op_q [5];
  logic [WORD_W-1:0] op_d [5];
  logic [WORD_W-1:0] res_data_q, res_data_d;
  logic              res_overflow_q, res_overflow_d;
  logic              res_timeout_q, res_timeout_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_guard_done;
  logic tmr_timeout;

  maxnet_host_timer #(
    .GUARD_CYCLES   (GUARD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (tmr_clr),
    .en         (tmr_en),
    .guard_done (tmr_guard_done),
    .timeout    (tmr_timeout)
  );

  // Next-state, operand load and result capture.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    op_d           = op_q;
    res_data_d     = res_data_q;
    res_overflow_d = res_overflow_q;
    res_timeout_d  = res_timeout_q;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;

    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          for (int i = 0; i < 5; i++) begin
            if (idx_q == 3'(i)) begin
              op_d[i] = bus.in_data;
            end
          end
          if (idx_q == IDX_A4) begin
            idx_d   = IDX_EPS;
            state_d = START;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      START: begin
        tmr_clr = 1'b1;
        state_d = WAIT;
      end

      WAIT: begin
        tmr_en = 1'b1;
        // Finish is checked first so it wins over a coincident timeout.
        if (tmr_guard_done && bus.mx_finish) begin
          res_data_d     = bus.mx_out;
          res_overflow_d = bus.mx_overflow;
          res_timeout_d  = 1'b0;
          state_d        = RESULT;
        end else if (tmr_timeout) begin
          res_data_d     = '0;
          res_overflow_d = 1'b0;
          res_timeout_d  = 1'b1;
          state_d        = RESULT;
        end
      end

      RESULT: begin
        if (bus.res_ready) begin
          state_d = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= LOAD;
      idx_q          <= IDX_EPS;
      res_data_q     <= '0;
      res_overflow_q <= 1'b0;
      res_timeout_q  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        op_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      res_data_q     <= res_data_d;
      res_overflow_q <= res_overflow_d;
      res_timeout_q  <= res_timeout_d;
      for (int i = 0; i < 5; i++) begin
        op_q[i] <= op_d[i];
      end
    end
  end

  // Handshake and strobe outputs decode straight from the registered state.
  assign bus.in_ready     = (state_q == LOAD);
  assign bus.mx_start     = (state_q == START);
  assign bus.res_valid    = (state_q == RESULT);
  assign bus.busy         = !((state_q == LOAD) && (idx_q == IDX_EPS));

  assign bus.mx_epsilon   = op_q[IDX_EPS];
  assign bus.mx_a1        = op_q[IDX_A1];
  assign bus.mx_a2        = op_q[IDX_A2];
  assign bus.mx_a3        = op_q[IDX_A3];
  assign bus.mx_a4        = op_q[IDX_A4];

  assign bus.res_data     = res_data_q;
  assign bus.res_overflow = res_overflow_q;
  assign bus.res_timeout  = res_timeout_q;

endmodule

// File: tb/tb_maxnet_host.sv
// Directed bench for maxnet_host with GUARD_CYCLES=2, TIMEOUT_CYCLES=16.
module tb_maxnet_host;

  localparam int W  = 32;
  localparam int G  = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  maxnet_host_if #(.WORD_W(W)) bus ();

  maxnet_host #(
    .WORD_W         (W),
    .GUARD_CYCLES   (G),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] rec [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] op_at(input int i);
    case (i)
      0:       return bus.mx_epsilon;
      1:       return bus.mx_a1;
      2:       return bus.mx_a2;
      3:       return bus.mx_a3;
      default: return bus.mx_a4;
    endcase
  endfunction

  // Streams rec[0..4] back to back; returns in the START cycle.
  task automatic load_record();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rec[i];
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  // Ticks until res_valid or the budget runs out; n is ticks taken.
  task automatic wait_res(input int max, output int n);
    n = 0;
    while (!bus.res_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0;
    bus.mx_finish = 1'b0; bus.mx_overflow = 1'b0; bus.mx_out = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.mx_start !== 1'b0) begin errors++; $display("FAIL reset_mx_start got=%0b exp=0", bus.mx_start); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0b exp=0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if ({bus.res_data, bus.res_overflow, bus.res_timeout} !== {W'(0), 2'b00}) begin
      errors++; $display("FAIL reset_result got=%h/%0b/%0b exp=0/0/0", bus.res_data, bus.res_overflow, bus.res_timeout);
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (op_at(i) !== '0) begin errors++; $display("FAIL reset_op%0d got=%h exp=0", i, op_at(i)); end
    end
  endtask

  task automatic test_basic();
    int starts;
    int bad;
    rec = '{32'h3DCCCCCD, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000};
    load_record();
    checks++; if (bus.mx_start !== 1'b1) begin errors++; $display("FAIL basic_start got=%0b exp=1", bus.mx_start); end
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL basic_start_ctrl in_ready=%0b busy=%0b exp 0/1", bus.in_ready, bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (op_at(i) !== rec[i]) begin errors++; $display("FAIL basic_op%0d got=%h exp=%h", i, op_at(i), rec[i]); end
    end
    starts = 0; bad = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.mx_start) starts++;
      if (bus.res_valid) bad++;
      for (int i = 0; i < 5; i++) if (op_at(i) !== rec[i]) bad++;
    end
    bus.mx_finish = 1'b1; bus.mx_out = 32'h40400000; bus.mx_overflow = 1'b0;
    tick();
    bus.mx_finish = 1'b0;
    checks++; if (starts != 0) begin errors++; $display("FAIL basic_extra_start got=%0d exp=0", starts); end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_wait_stable got=%0d bad exp=0", bad); end
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL basic_res_valid got=%0b exp=1", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h40400000) begin errors++; $display("FAIL basic_res_data got=%h exp=40400000", bus.res_data); end
    checks++; if (bus.res_overflow !== 1'b0 || bus.res_timeout !== 1'b0) begin
      errors++; $display("FAIL basic_flags ovf=%0b to=%0b exp 0/0", bus.res_overflow, bus.res_timeout);
    end
    drain();
    checks++; if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_drain valid=%0b in_ready=%0b busy=%0b exp 0/1/0", bus.res_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    rec = '{32'h00000001, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = (i % 2 == 0) ? rec[i/2] : 32'hDEADBEEF;
      tick();
      if (i == 0) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_busy_mid_load got=%0b exp=1", bus.busy); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.mx_start !== 1'b1) begin errors++; $display("FAIL bp_start got=%0b exp=1", bus.mx_start); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (op_at(i) !== rec[i]) begin errors++; $display("FAIL bp_op%0d got=%h exp=%h", i, op_at(i), rec[i]); end
    end
    // Finish already high at START: first unguarded WAIT cycle captures it.
    bus.mx_finish = 1'b1; bus.mx_out = 32'h5555AAAA; bus.mx_overflow = 1'b1;
    wait_res(30, n);
    bus.mx_finish = 1'b0; bus.mx_overflow = 1'b0;
    checks++; if (n != G + 2) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", n, G + 2); end
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h5555AAAA || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_res_hold got=%0d bad cycles exp=0", bad); end
    checks++; if (bus.res_overflow !== 1'b1) begin errors++; $display("FAIL bp_res_overflow got=%0b exp=1", bus.res_overflow); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++; if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_return valid=%0b in_ready=%0b exp 0/1", bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_stale_finish();
    int bad;
    rec = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    bus.mx_finish = 1'b1; bus.mx_out = 32'hBAD0BAD0; bus.mx_overflow = 1'b1;
    load_record();
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.res_valid) bad++;
      if (k == 3) begin bus.mx_finish = 1'b0; bus.mx_out = '0; bus.mx_overflow = 1'b0; end
    end
    bus.mx_finish = 1'b1; bus.mx_out = 32'h12345678; bus.mx_overflow = 1'b0;
    tick();
    bus.mx_finish = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL stale_early_capture got=%0d early cycles exp=0", bad); end
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h12345678) begin
      errors++; $display("FAIL stale_capture valid=%0b data=%h exp 1/12345678", bus.res_valid, bus.res_data);
    end
    checks++; if (bus.res_overflow !== 1'b0) begin errors++; $display("FAIL stale_overflow got=%0b exp=0", bus.res_overflow); end
    drain();
  endtask

  task automatic test_timeout();
    int n;
    rec = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
    bus.mx_finish = 1'b0; bus.mx_out = 32'hFFFFFFFF; bus.mx_overflow = 1'b1;
    load_record();
    wait_res(40, n);
    checks++; if (n != TO + 1) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", n, TO + 1); end
    checks++; if (bus.res_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got=%0b exp=1", bus.res_timeout); end
    checks++; if (bus.res_data !== '0 || bus.res_overflow !== 1'b0) begin
      errors++; $display("FAIL timeout_result data=%h ovf=%0b exp 0/0", bus.res_data, bus.res_overflow);
    end
    bus.mx_overflow = 1'b0; bus.mx_out = '0;
    drain();
  endtask

  task automatic test_finish_on_timeout();
    int bad;
    rec = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D, 32'h0000000E};
    load_record();
    bad = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (bus.res_valid) bad++;
    end
    bus.mx_finish = 1'b1; bus.mx_out = 32'h000000AA; bus.mx_overflow = 1'b1;
    tick();
    bus.mx_finish = 1'b0; bus.mx_overflow = 1'b0; bus.mx_out = '0;
    checks++; if (bad != 0) begin errors++; $display("FAIL fot_early got=%0d early cycles exp=0", bad); end
    checks++; if (bus.res_valid !== 1'b1 || bus.res_timeout !== 1'b0) begin
      errors++; $display("FAIL fot_finish_wins valid=%0b to=%0b exp 1/0", bus.res_valid, bus.res_timeout);
    end
    checks++; if (bus.res_data !== 32'h000000AA || bus.res_overflow !== 1'b1) begin
      errors++; $display("FAIL fot_result data=%h ovf=%0b exp 000000aa/1", bus.res_data, bus.res_overflow);
    end
    drain();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int bad;
    rec = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
    load_record();
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.mx_start !== 1'b0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstw_ctrl in_ready=%0b start=%0b valid=%0b busy=%0b exp 1/0/0/0",
                         bus.in_ready, bus.mx_start, bus.res_valid, bus.busy);
    end
    checks++; if ({bus.res_data, bus.res_overflow, bus.res_timeout} !== {W'(0), 2'b00}) begin
      errors++; $display("FAIL rstw_result got=%h/%0b/%0b exp 0/0/0", bus.res_data, bus.res_overflow, bus.res_timeout);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) if (op_at(i) !== '0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rstw_ops got=%0d nonzero exp=0", bad); end
    // Late finish from the aborted run must be ignored in LOAD.
    bus.mx_finish = 1'b1; bus.mx_out = 32'h00000077; bus.mx_overflow = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
    end
    bus.mx_finish = 1'b0; bus.mx_overflow = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL rstw_late_finish got=%0d bad cycles exp=0", bad); end
    rec = '{32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004, 32'hF0000005};
    load_record();
    bad = 0;
    for (int i = 0; i < 5; i++) if (op_at(i) !== rec[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rstw_reload got=%0d bad ops exp=0", bad); end
    for (int k = 0; k < 5; k++) tick();
    bus.mx_finish = 1'b1; bus.mx_out = 32'hCAFEF00D; bus.mx_overflow = 1'b0;
    wait_res(30, n);
    bus.mx_finish = 1'b0;
    checks++; if (n != 1 || bus.res_data !== 32'hCAFEF00D || bus.res_timeout !== 1'b0) begin
      errors++; $display("FAIL rstw_rerun n=%0d data=%h to=%0b exp 1/cafef00d/0", n, bus.res_data, bus.res_timeout);
    end
    drain();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstw_final_in_ready got=%0b exp=1", bus.in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stale_finish();
    test_timeout();
    test_finish_on_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
